// File: rtl/axil_timer_bank.sv
// axil_timer_bank: N-channel down-counting timer bank behind AXI4-Lite; TIMER_PRESCALER_EN adds a global PRESCALE at 0x800
module axil_timer_bank #(
    parameter int NUM_TIMERS_p = 4,
    parameter int CNT_BW_p     = 32,
    parameter int ADDR_BW_p    = 15,
    parameter int DATA_BW_p    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_BW_p-1:0]    s_axil_awaddr_i,
    input  logic                    s_axil_awvalid_i,
    output logic                    s_axil_awready_o,
    input  logic [DATA_BW_p-1:0]    s_axil_wdata_i,
    input  logic [3:0]              s_axil_wstrb_i,
    input  logic                    s_axil_wvalid_i,
    output logic                    s_axil_wready_o,
    output logic [1:0]              s_axil_bresp_o,
    output logic                    s_axil_bvalid_o,
    input  logic                    s_axil_bready_i,
    input  logic [ADDR_BW_p-1:0]    s_axil_araddr_i,
    input  logic                    s_axil_arvalid_i,
    output logic                    s_axil_arready_o,
    output logic [DATA_BW_p-1:0]    s_axil_rdata_o,
    output logic [1:0]              s_axil_rresp_o,
    output logic                    s_axil_rvalid_o,
    input  logic                    s_axil_rready_i,
    output logic [NUM_TIMERS_p-1:0] irq_o
);
    logic                    live, aw_held, w_held, wr_fire, wr_map, tick, unused_bits;
    logic [11:0]             aw_off, rd_off;
    logic [DATA_BW_p-1:0]    w_data, w_mask, rd_word;
    logic [3:0]              w_strb;
    logic [NUM_TIMERS_p-1:0] en, reload, irq_en, expired;
    logic [CNT_BW_p-1:0]     load  [NUM_TIMERS_p];
    logic [CNT_BW_p-1:0]     count [NUM_TIMERS_p];
`ifdef TIMER_PRESCALER_EN
    logic [15:0]             prescale, div;
`endif

    function automatic logic is_mapped(input logic [11:0] off);
`ifdef TIMER_PRESCALER_EN
        return (int'(off) < NUM_TIMERS_p * 16) || off == 12'h800;
`else
        return int'(off) < NUM_TIMERS_p * 16;
`endif
    endfunction

    // readies stay low until the cycle after reset releases
    assign s_axil_awready_o = live & ~aw_held & ~s_axil_bvalid_o;
    assign s_axil_wready_o  = live & ~w_held & ~s_axil_bvalid_o;
    assign s_axil_arready_o = live & ~s_axil_rvalid_o;
    assign wr_fire          = aw_held & w_held;
    assign wr_map           = is_mapped(aw_off);
    assign w_mask           = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    assign rd_off           = s_axil_araddr_i[11:0];
    assign unused_bits      = ^{s_axil_awaddr_i[ADDR_BW_p-1:12], s_axil_araddr_i[ADDR_BW_p-1:12], aw_off[1:0], rd_off[1:0]};

    always_comb begin
        rd_word = '0;
        for (int n = 0; n < NUM_TIMERS_p; n++)
            if (int'(rd_off[11:4]) == n)
                rd_word = rd_off[3:2] == 2'd0 ? DATA_BW_p'({irq_en[n], reload[n], en[n]}) :
                          rd_off[3:2] == 2'd1 ? DATA_BW_p'(load[n]) :
                          rd_off[3:2] == 2'd2 ? DATA_BW_p'(count[n]) : DATA_BW_p'(expired[n]);
`ifdef TIMER_PRESCALER_EN
        if (rd_off == 12'h800)
            rd_word = DATA_BW_p'(prescale);
`endif
        if (!is_mapped(rd_off))
            rd_word = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            live            <= 1'b0;
            aw_held         <= 1'b0;
            w_held          <= 1'b0;
            aw_off          <= '0;
            w_data          <= '0;
            w_strb          <= '0;
            s_axil_bvalid_o <= 1'b0;
            s_axil_bresp_o  <= 2'b00;
            s_axil_rvalid_o <= 1'b0;
            s_axil_rresp_o  <= 2'b00;
            s_axil_rdata_o  <= '0;
        end else begin
            live <= 1'b1;
            if (s_axil_awvalid_i && s_axil_awready_o) begin
                aw_held <= 1'b1;
                aw_off  <= s_axil_awaddr_i[11:0];
            end
            if (s_axil_wvalid_i && s_axil_wready_o) begin
                w_held <= 1'b1;
                w_data <= s_axil_wdata_i;
                w_strb <= s_axil_wstrb_i;
            end
            if (wr_fire) begin
                aw_held         <= 1'b0;
                w_held          <= 1'b0;
                s_axil_bvalid_o <= 1'b1;
                s_axil_bresp_o  <= wr_map ? 2'b00 : 2'b10;
            end else if (s_axil_bvalid_o && s_axil_bready_i) begin
                s_axil_bvalid_o <= 1'b0;
            end
            if (s_axil_arvalid_i && s_axil_arready_o) begin
                s_axil_rvalid_o <= 1'b1;
                s_axil_rdata_o  <= rd_word;
                s_axil_rresp_o  <= is_mapped(rd_off) ? 2'b00 : 2'b10;
            end else if (s_axil_rvalid_o && s_axil_rready_i) begin
                s_axil_rvalid_o <= 1'b0;
            end
        end
    end

`ifdef TIMER_PRESCALER_EN
    assign tick = div == prescale;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prescale <= '0;
            div      <= '0;
        end else if (wr_fire && aw_off == 12'h800) begin
            prescale <= (prescale & ~w_mask[15:0]) | (w_data[15:0] & w_mask[15:0]);
            div      <= '0;
        end else begin
            div <= tick ? 16'd0 : div + 16'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar g = 0; g < NUM_TIMERS_p; g++) begin : g_ch
        logic                hit, ctrl_wr, load_wr, w1c, c_en, c_rl, c_ie, zero;
        logic                en_q, rl_q, ie_q, exp_q;
        logic [CNT_BW_p-1:0] load_q, cnt_q;
        assign hit     = wr_fire && wr_map && int'(aw_off[11:4]) == g;
        assign ctrl_wr = hit && aw_off[3:2] == 2'd0 && w_strb[0];
        assign load_wr = hit && aw_off[3:2] == 2'd1;
        assign w1c     = hit && aw_off[3:2] == 2'd3 && w_strb[0] && w_data[0];
        // effective control for this edge: a CTRL write overrides the expiry tick
        assign {c_ie, c_rl, c_en} = ctrl_wr ? w_data[2:0] : {ie_q, rl_q, en_q};
        assign zero    = cnt_q == '0;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                en_q   <= 1'b0;
                rl_q   <= 1'b0;
                ie_q   <= 1'b0;
                exp_q  <= 1'b0;
                load_q <= '0;
                cnt_q  <= '0;
            end else begin
                ie_q <= c_ie;
                rl_q <= c_rl;
                if (load_wr)
                    load_q <= CNT_BW_p'((DATA_BW_p'(load_q) & ~w_mask) | (w_data & w_mask));
                if (c_en && !en_q) begin
                    en_q  <= 1'b1;
                    cnt_q <= load_q;
                end else if (!c_en) begin
                    en_q <= 1'b0;
                end else if (tick && zero) begin
                    en_q  <= c_rl;
                    cnt_q <= c_rl ? load_q : cnt_q;
                end else if (tick) begin
                    cnt_q <= cnt_q - CNT_BW_p'(1);
                end
                exp_q <= (c_en && en_q && tick && zero) || (exp_q && !w1c);
            end
        end
        assign en[g]      = en_q;
        assign reload[g]  = rl_q;
        assign irq_en[g]  = ie_q;
        assign expired[g] = exp_q;
        assign load[g]    = load_q;
        assign count[g]   = cnt_q;
        assign irq_o[g]   = exp_q & ie_q;
    end
endmodule

// File: tb/tb_axil_timer_bank.sv
// tb_axil_timer_bank: directed and randomized AXI-Lite traffic against a transaction-level timer model
module tb_axil_timer_bank;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [N-1:0] irq_o;

    always #5 clk = ~clk;

    axil_timer_bank #(.NUM_TIMERS_p(N), .CNT_BW_p(32), .ADDR_BW_p(15), .DATA_BW_p(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axil_awaddr_i(awaddr), .s_axil_awvalid_i(awvalid), .s_axil_awready_o(awready),
        .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid), .s_axil_wready_o(wready),
        .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
        .s_axil_araddr_i(araddr), .s_axil_arvalid_i(arvalid), .s_axil_arready_o(arready),
        .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid), .s_axil_rready_i(rready),
        .irq_o(irq_o)
    );

    int cmp_cnt = 0, err_cnt = 0, cyc = 0, b_cyc = 0;
    logic [N-1:0] b_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string what);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s: timed out at cycle %0d", what, cyc);
    endtask

    // ---------------- reference model ----------------
    bit          m_en[N], m_rl[N], m_ie[N], m_exp[N];
    int unsigned m_load[N], m_cnt[N];
    bit          m_live, aw_p, w_p, m_bv, m_rv;
    logic [11:0] aw_a;
    logic [31:0] w_d, m_rdata;
    logic [3:0]  w_s;
    logic [1:0]  m_bresp, m_rresp;
`ifdef TIMER_PRESCALER_EN
    int unsigned m_pre, m_div;
`endif

    function automatic bit is_mapped(input logic [11:0] a);
`ifdef TIMER_PRESCALER_EN
        return int'(a) < N * 16 || a == 12'h800;
`else
        return int'(a) < N * 16;
`endif
    endfunction

    function automatic logic [31:0] reg_val(input logic [11:0] a);
        int c;
        c = int'(a[11:4]);
        if (!is_mapped(a)) return 32'h0;
`ifdef TIMER_PRESCALER_EN
        if (a == 12'h800) return m_pre;
`endif
        case (a[3:2])
            2'd0: return {29'h0, m_ie[c], m_rl[c], m_en[c]};
            2'd1: return m_load[c];
            2'd2: return m_cnt[c];
            default: return {31'h0, m_exp[c]};
        endcase
    endfunction

    always @(posedge clk) begin
        bit acc_aw, acc_w, acc_ar, do_wr, wm, tk, ne, set, hit;
        int c;
        int unsigned ld;
        logic [31:0] bm;
        cyc++;
        if (rst) begin
            for (int n = 0; n < N; n++) begin
                m_en[n] = 0; m_rl[n] = 0; m_ie[n] = 0; m_exp[n] = 0; m_load[n] = 0; m_cnt[n] = 0;
            end
            m_live = 0; aw_p = 0; w_p = 0; m_bv = 0; m_rv = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
`ifdef TIMER_PRESCALER_EN
            m_pre = 0; m_div = 0;
`endif
        end else begin
            acc_ar = m_live && arvalid && !m_rv;
            acc_aw = m_live && awvalid && !aw_p && !m_bv;
            acc_w  = m_live && wvalid && !w_p && !m_bv;
            do_wr  = aw_p && w_p;
            tk = 1;
`ifdef TIMER_PRESCALER_EN
            tk = (m_div == m_pre);
`endif
            if (acc_ar) begin
                m_rv = 1;
                m_rdata = reg_val(araddr[11:0]);
                m_rresp = is_mapped(araddr[11:0]) ? 2'b00 : 2'b10;
            end else if (m_rv && rready) m_rv = 0;
            wm = do_wr && is_mapped(aw_a);
            c = int'(aw_a[11:4]);
            bm = {{8{w_s[3]}}, {8{w_s[2]}}, {8{w_s[1]}}, {8{w_s[0]}}};
            for (int n = 0; n < N; n++) begin
                hit = wm && c == n;
                ne = m_en[n];
                set = 0;
                ld = m_load[n];
                if (hit && aw_a[3:2] == 0 && w_s[0]) begin
                    ne = w_d[0]; m_rl[n] = w_d[1]; m_ie[n] = w_d[2];
                end
                if (ne && !m_en[n]) m_cnt[n] = ld;
                else if (ne && tk) begin
                    if (m_cnt[n] != 0) m_cnt[n] = m_cnt[n] - 1;
                    else begin
                        set = 1;
                        if (m_rl[n]) m_cnt[n] = ld;
                        else ne = 0;
                    end
                end
                m_en[n] = ne;
                if (set) m_exp[n] = 1;
                else if (hit && aw_a[3:2] == 3 && w_s[0] && w_d[0]) m_exp[n] = 0;
                if (hit && aw_a[3:2] == 1) m_load[n] = (ld & ~bm) | (w_d & bm);
            end
`ifdef TIMER_PRESCALER_EN
            if (wm && aw_a == 12'h800) begin
                m_pre = (m_pre & ~bm[15:0] & 32'hFFFF) | (w_d & bm & 32'hFFFF);
                m_div = 0;
            end else m_div = tk ? 0 : m_div + 1;
`endif
            if (do_wr) begin
                m_bv = 1; m_bresp = is_mapped(aw_a) ? 2'b00 : 2'b10; aw_p = 0; w_p = 0;
            end else if (m_bv && bready) m_bv = 0;
            if (acc_aw) begin aw_p = 1; aw_a = awaddr[11:0]; end
            if (acc_w) begin w_p = 1; w_d = wdata; w_s = wstrb; end
            m_live = 1;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e;
        for (int n = 0; n < N; n++) e[n] = m_exp[n] & m_ie[n];
        check("irq", irq_o, e);
        check("bvalid", bvalid, m_bv);
        check("rvalid", rvalid, m_rv);
        check("awready", awready, m_live && !aw_p && !m_bv);
        check("wready", wready, m_live && !w_p && !m_bv);
        check("arready", arready, m_live && !m_rv);
        if (m_bv) check("bresp", bresp, m_bresp);
        if (m_rv) begin
            check("rdata", rdata, m_rdata);
            check("rresp", rresp, m_rresp);
        end
    end

    // ---------------- bus tasks (start and end on a falling edge) ----------------
    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int bdelay, output logic [1:0] resp);
        bit awd, wd, haw, hw;
        int t, aw_at, w_at;
        awd = 0; wd = 0; t = 0;
        aw_at = lead > 0 ? lead : 0;
        w_at  = lead < 0 ? -lead : 0;
        awaddr = 15'(a); wdata = d; wstrb = s;
        awvalid = (aw_at == 0);
        wvalid  = (w_at == 0);
        while (!(awd && wd)) begin
            haw = awvalid && awready;
            hw  = wvalid && wready;
            @(negedge clk);
            t++;
            if (haw) begin awvalid = 0; awd = 1; end
            if (hw) begin wvalid = 0; wd = 1; end
            if (!awd && t >= aw_at) awvalid = 1;
            if (!wd && t >= w_at) wvalid = 1;
            if (t > 100) begin
                timeout_fail("write_addr_data");
                awvalid = 0; wvalid = 0;
                break;
            end
        end
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        if (!bvalid) timeout_fail("write_resp");
        resp = bresp; b_cyc = cyc; b_irq = irq_o;
        repeat (bdelay) @(negedge clk);
        bready = 1;
        @(negedge clk);
        bready = 0;
    endtask

    task automatic axi_read(input logic [11:0] a, input int rdelay, output logic [31:0] d, output logic [1:0] resp);
        bit h;
        int t;
        t = 0;
        araddr = 15'(a);
        arvalid = 1;
        forever begin
            h = arready;
            @(negedge clk);
            t++;
            if (h) break;
            if (t > 100) begin timeout_fail("read_addr"); break; end
        end
        arvalid = 0;
        t = 0;
        while (!rvalid && t < 100) begin @(negedge clk); t++; end
        if (!rvalid) timeout_fail("read_data");
        d = rdata; resp = rresp;
        repeat (rdelay) @(negedge clk);
        rready = 1;
        @(negedge clk);
        rready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  rs;
        logic [31:0] rd, d;
        logic [11:0] a;
        logic [3:0]  s;
        int t, k;
        repeat (2) @(negedge clk);
        check("rst_irq", irq_o, 0);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        rst = 0;
        @(negedge clk);
        axi_read(12'h008, 0, rd, rs);
        check("rst_count", rd, 32'h0);
        check("rst_count_resp", rs, 2'b00);

        // one-shot on channel 1
        axi_write(12'h014, 32'd5, 4'hF, 0, 0, rs);
        axi_write(12'h010, 32'h5, 4'hF, 0, 0, rs);
        t = 0;
        while (!irq_o[1] && t < 50) begin @(negedge clk); t++; end
        check("oneshot_delay", cyc - b_cyc, 6);
        axi_read(12'h010, 0, rd, rs);
        check("oneshot_ctrl", rd, 32'h4);
        axi_read(12'h018, 0, rd, rs);
        check("oneshot_count", rd, 32'h0);
        axi_write(12'h01C, 32'h1, 4'hF, 0, 0, rs);
        check("oneshot_w1c_irq", b_irq[1], 0);

        // auto-reload on channel 0: first W1C lands on an expiry edge, second between expiries
        axi_write(12'h004, 32'd3, 4'hF, 0, 0, rs);
        axi_write(12'h000, 32'h7, 4'hF, 0, 0, rs);
        @(negedge clk);
        axi_write(12'h00C, 32'h1, 4'hF, 0, 0, rs);
        check("w1c_vs_expiry", b_irq[0], 1);
        axi_write(12'h00C, 32'h1, 4'hF, 0, 0, rs);
        check("w1c_clear", b_irq[0], 0);
        repeat (10) @(negedge clk);
        axi_write(12'h000, 32'h0, 4'hF, 0, 0, rs);

        // W leads AW by 3 cycles, response stalled for 5
        axi_write(12'h024, 32'hA5A5_1234, 4'hF, 3, 5, rs);
        check("order_bresp", rs, 2'b00);
        araddr = 15'h024;
        arvalid = 1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        araddr = 15'h020;
        repeat (3) begin
            check("ar_stall", arready, 0);
            @(negedge clk);
        end
        check("order_load", rdata, 32'hA5A5_1234);
        rready = 1;
        @(negedge clk);
        rready = 0;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 0;
        check("second_ar_data", rdata, 32'h0);
        rready = 1;
        @(negedge clk);
        rready = 0;

        // unmapped space
        axi_read(12'h0F0, 0, rd, rs);
        check("unmapped_rdata", rd, 32'h0);
        check("unmapped_rresp", rs, 2'b10);
        axi_write(12'h0F0, 32'hFFFF_FFFF, 4'hF, 0, 0, rs);
        check("unmapped_bresp", rs, 2'b10);
`ifdef TIMER_PRESCALER_EN
        axi_write(12'h800, 32'd9, 4'hF, 0, 0, rs);
        check("prescale_bresp", rs, 2'b00);
        axi_write(12'h024, 32'd1, 4'hF, 0, 0, rs);
        axi_write(12'h020, 32'h5, 4'hF, 0, 0, rs);
        t = 0;
        while (!irq_o[2] && t < 60) begin @(negedge clk); t++; end
        check("prescale_window", (cyc - b_cyc >= 10) && (cyc - b_cyc <= 30), 1);
`else
        axi_read(12'h800, 0, rd, rs);
        check("prescale_absent_rresp", rs, 2'b10);
        check("prescale_absent_rdata", rd, 32'h0);
`endif

        // randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            a = k == 0 ? 12'h0F0 : k == 1 ? 12'h800 : 12'(($urandom_range(0, N - 1) << 4) | ($urandom_range(0, 3) << 2));
            if ($urandom_range(0, 1) == 1) begin
                d = a[3:2] == 2'd1 ? 32'($urandom_range(0, 12)) : a == 12'h800 ? 32'($urandom_range(0, 3)) : $urandom;
                s = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF;
                axi_write(a, d, s, int'($urandom_range(0, 6)) - 3, $urandom_range(0, 3), rs);
            end else begin
                axi_read(a, $urandom_range(0, 3), rd, rs);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // reset in the middle of pending handshakes
        araddr = 15'h004; awaddr = 15'h004; wdata = 32'h77; wstrb = 4'hF;
        arvalid = 1; awvalid = 1; wvalid = 1;
        @(negedge clk);
        rst = 1;
        arvalid = 0; awvalid = 0; wvalid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        axi_read(12'h004, 0, rd, rs);
        check("post_reset_load", rd, 32'h0);
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
